// File: rtl/image_writer_pkg.sv
// Shared types and constants for the image RAM writer.
//   writer_state_t : FSM states of the writer
//   lane_idx_t     : byte lane index within one packed word
//   NUM_BANKS      : banks written in parallel
//   CKSUM_W        : width of the running byte checksum
package image_writer_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } writer_state_t;

   typedef logic [1:0] lane_idx_t;

   localparam int NUM_BANKS = 4;
   localparam int CKSUM_W   = 16;

endpackage

// File: rtl/image_ram_writer_if.sv
// Byte stream in / four-bank image RAM write port out.
//   in_data, in_valid, in_ready : valid/ready byte stream
//   addr_b                      : shared bank write address
//   data_b0..3, we_b0..3        : per-bank write data and enables
// Modports: master = the writer, slave = stream source plus RAM side.
interface image_ram_writer_if #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 8
);
   logic [DATA_W-1:0] in_data;
   logic              in_valid;
   logic              in_ready;
   logic [ADDR_W-1:0] addr_b;
   logic [DATA_W-1:0] data_b0;
   logic [DATA_W-1:0] data_b1;
   logic [DATA_W-1:0] data_b2;
   logic [DATA_W-1:0] data_b3;
   logic              we_b0;
   logic              we_b1;
   logic              we_b2;
   logic              we_b3;

   modport master (
      input  in_data, in_valid,
      output in_ready, addr_b,
      output data_b0, data_b1, data_b2, data_b3,
      output we_b0, we_b1, we_b2, we_b3
   );

   modport slave (
      output in_data, in_valid,
      input  in_ready, addr_b,
      input  data_b0, data_b1, data_b2, data_b3,
      input  we_b0, we_b1, we_b2, we_b3
   );
endinterface

// File: rtl/image_word_packer.sv
// Collects consecutive stream bytes into one NUM_BANKS-lane word.
//   clk, reset : clock, asynchronous active-high reset
//   clear      : restart at lane 0 (new load or abort)
//   accept     : a byte is taken this cycle
//   in_data    : the byte
//   word       : lane registers, lane k in bits [k*DATA_W +: DATA_W]
//   word_full  : the byte taken this cycle completes the word
module image_word_packer
   import image_writer_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        clear,
   input  logic                        accept,
   input  logic [DATA_W-1:0]           in_data,
   output logic [NUM_BANKS*DATA_W-1:0] word,
   output logic                        word_full
);

   lane_idx_t         lane_cnt;
   logic [DATA_W-1:0] lanes [NUM_BANKS];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lane_cnt <= '0;
         for (int i = 0; i < NUM_BANKS; i++) lanes[i] <= '0;
      end else if (clear) begin
         lane_cnt <= '0;
      end else if (accept) begin
         lanes[lane_cnt] <= in_data;
         lane_cnt        <= lane_cnt + lane_idx_t'(1);
      end
   end

   always_comb begin
      word = '0;
      for (int i = 0; i < NUM_BANKS; i++) word[i*DATA_W +: DATA_W] = lanes[i];
   end

   // A byte that arrives together with clear is dropped, so it cannot complete a word.
   assign word_full = accept && !clear && (lane_cnt == lane_idx_t'(NUM_BANKS - 1));

endmodule

// File: rtl/image_ram_writer.sv
// Write-side initiator for the four image RAM banks.
// Packs the incoming byte stream into 4-byte words (byte k -> bank k%4) and
// commits each word to all banks at address k/4 in a single write.
//   clk, reset : clock, asynchronous active-high reset
//   start      : pulse, begin loading an image at address 0 (from IDLE/DONE)
//   abort      : pulse, drop the current load and return to IDLE
//   bus        : byte stream in, bank write port out (image_ram_writer_if.master)
//   busy       : high in FILL or WRITE
//   done       : high while in DONE
//   checksum   : 16-bit running byte sum
// Build option: define IMAGE_WRITER_CHECKSUM_EN to enable the checksum adder;
// without it checksum is tied to zero.
module image_ram_writer
   import image_writer_pkg::*;
#(
   parameter int ADDR_W    = 10,
   parameter int DATA_W    = 8,
   parameter int NUM_BANKS = 4,
   parameter int IMG_WORDS = 784
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic                abort,
   image_ram_writer_if.master  bus,
   output logic                busy,
   output logic                done,
   output logic [CKSUM_W-1:0]  checksum
);

   writer_state_t               state_q;
   writer_state_t               state_d;
   logic [ADDR_W-1:0]           word_cnt;
   logic [NUM_BANKS*DATA_W-1:0] word;
   logic                        word_full;
   logic                        accept;
   logic                        in_ready;
   logic                        load_start;
   logic                        commit;
   logic                        last_word;
   logic [ADDR_W-1:0]           addr_q;
   logic [NUM_BANKS*DATA_W-1:0] data_q;
   logic                        we_q;

   assign accept    = bus.in_valid && in_ready;
   assign last_word = (word_cnt == ADDR_W'(IMG_WORDS - 1));

   image_word_packer #(
      .DATA_W (DATA_W)
   ) u_packer (
      .clk       (clk),
      .reset     (reset),
      .clear     (abort || load_start),
      .accept    (accept),
      .in_data   (bus.in_data),
      .word      (word),
      .word_full (word_full)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (abort) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    if (start) state_d = FILL;
            FILL:    if (word_full) state_d = WRITE;
            WRITE:   state_d = last_word ? DONE : FILL;
            DONE:    if (start) state_d = FILL;
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      in_ready   = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      load_start = 1'b0;
      commit     = 1'b0;
      case (state_q)
         IDLE:  load_start = start && !abort;
         FILL:  begin
            in_ready = 1'b1;
            busy     = 1'b1;
         end
         WRITE: begin
            busy   = 1'b1;
            commit = !abort;
         end
         DONE:  begin
            done       = 1'b1;
            load_start = start && !abort;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                        word_cnt <= '0;
      else if (abort || load_start)     word_cnt <= '0;
      else if (commit && !last_word)    word_cnt <= word_cnt + ADDR_W'(1);
   end

   // The write port is registered out of the WRITE cycle, so an abort seen
   // during WRITE still suppresses the commit and no enable ever escapes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         we_q   <= 1'b0;
         addr_q <= '0;
         data_q <= '0;
      end else begin
         we_q <= commit;
         if (commit) begin
            addr_q <= word_cnt;
            data_q <= word;
         end
      end
   end

`ifdef IMAGE_WRITER_CHECKSUM_EN
   logic [CKSUM_W-1:0] cksum_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)           cksum_q <= '0;
      else if (load_start) cksum_q <= '0;
      else if (accept)     cksum_q <= cksum_q + CKSUM_W'(bus.in_data);
   end

   assign checksum = cksum_q;
`else
   assign checksum = '0;
`endif

   assign bus.in_ready = in_ready;
   assign bus.addr_b   = addr_q;
   assign bus.data_b0  = data_q[0*DATA_W +: DATA_W];
   assign bus.data_b1  = data_q[1*DATA_W +: DATA_W];
   assign bus.data_b2  = data_q[2*DATA_W +: DATA_W];
   assign bus.data_b3  = data_q[3*DATA_W +: DATA_W];
   assign bus.we_b0    = we_q;
   assign bus.we_b1    = we_q;
   assign bus.we_b2    = we_q;
   assign bus.we_b3    = we_q;

endmodule

// File: tb/tb_image_ram_writer.sv
// Bench for image_ram_writer with a two-word image. Expected bank writes are
// queued when a word is driven and compared when a write enable appears.
module tb_image_ram_writer;

   localparam int ADDR_W    = 10;
   localparam int DATA_W    = 8;
   localparam int IMG_WORDS = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        abort;
   logic        busy;
   logic        done;
   logic [15:0] checksum;

   image_ram_writer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   image_ram_writer #(
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .NUM_BANKS (4),
      .IMG_WORDS (IMG_WORDS)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .abort    (abort),
      .bus      (bus),
      .busy     (busy),
      .done     (done),
      .checksum (checksum)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [31:0]       data;
   } wr_t;

   wr_t exp_q[$];
   int  checks   = 0;
   int  errors   = 0;
   int  we_count = 0;

   // Write monitor / scoreboard
   always @(negedge clk) begin
      if (!reset && (bus.we_b0 || bus.we_b1 || bus.we_b2 || bus.we_b3)) begin
         wr_t e;
         we_count++;
         checks++;
         if ({bus.we_b3, bus.we_b2, bus.we_b1, bus.we_b0} !== 4'hF) begin
            errors++;
            $display("FAIL we_lanes: got %b required 1111", {bus.we_b3, bus.we_b2, bus.we_b1, bus.we_b0});
         end
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: got addr %0h data %h required no write", bus.addr_b,
                     {bus.data_b3, bus.data_b2, bus.data_b1, bus.data_b0});
         end else begin
            e = exp_q.pop_front();
            if (bus.addr_b !== e.addr || {bus.data_b3, bus.data_b2, bus.data_b1, bus.data_b0} !== e.data) begin
               errors++;
               $display("FAIL write_word: got addr %0h data %h required addr %0h data %h", bus.addr_b,
                        {bus.data_b3, bus.data_b2, bus.data_b1, bus.data_b0}, e.addr, e.data);
            end
         end
      end
   end

   // Stimulus helpers (all leave the bench 1 time unit after a rising edge)
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic pulse_abort();
      abort = 1'b1;
      step();
      abort = 1'b0;
   endtask

   task automatic expect_word(input logic [ADDR_W-1:0] a, input logic [7:0] b0, b1, b2, b3);
      exp_q.push_back('{addr: a, data: {b3, b2, b1, b0}});
   endtask

   task automatic send_byte(input logic [7:0] b);
      logic acc;
      acc          = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      for (int t = 0; t < 20 && !acc; t++) begin
         @(negedge clk);
         acc = bus.in_ready;
         step();
      end
      if (!acc) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: byte %h not accepted within 20 cycles", b);
      end
   endtask

   task automatic send_word(input logic [7:0] b0, b1, b2, b3);
      send_byte(b0);
      send_byte(b1);
      send_byte(b2);
      send_byte(b3);
   endtask

   task automatic wait_done();
      logic seen;
      seen = 1'b0;
      for (int t = 0; t < 30 && !seen; t++) begin
         @(negedge clk);
         seen = done;
         if (!seen) step();
      end
      if (seen) step();
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL done_timeout: done got 0 required 1 within 30 cycles");
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      idle(2);
      checks++;
      if ({busy, done, bus.in_ready, bus.we_b0, bus.we_b1, bus.we_b2, bus.we_b3} !== 7'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got %b required 0000000",
                  {busy, done, bus.in_ready, bus.we_b0, bus.we_b1, bus.we_b2, bus.we_b3});
      end
      checks++;
      if ({bus.addr_b, bus.data_b0, bus.data_b1, bus.data_b2, bus.data_b3, checksum} !== '0) begin
         errors++;
         $display("FAIL reset_data: addr %h data %h%h%h%h cksum %h required all 0", bus.addr_b,
                  bus.data_b3, bus.data_b2, bus.data_b1, bus.data_b0, checksum);
      end
      reset = 1'b0;
      step();
   endtask

   task automatic test_basic();
      int base;
      base = we_count;
      pulse_start();
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL basic_fill: busy %b in_ready %b required 1 1", busy, bus.in_ready);
      end
      step();
      expect_word(0, 8'h00, 8'h01, 8'h02, 8'h03);
      expect_word(1, 8'h04, 8'h05, 8'h06, 8'h07);
      for (int i = 0; i < 8; i++) send_byte(8'(i));
      bus.in_valid = 1'b0;
      wait_done();
      @(negedge clk);
      checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL basic_done: done %b busy %b required 1 0", done, busy);
      end
      idle(3);
      checks++;
      if (we_count - base != 2) begin
         errors++;
         $display("FAIL basic_we_count: got %0d required 2", we_count - base);
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL basic_pending: got %0d queued writes required 0", exp_q.size());
      end
`ifdef IMAGE_WRITER_CHECKSUM_EN
      checks++;
      if (checksum !== 16'h001C) begin
         errors++;
         $display("FAIL basic_checksum: got %h required 001c", checksum);
      end
`else
      checks++;
      if (checksum !== 16'h0000) begin
         errors++;
         $display("FAIL basic_checksum: got %h required 0000", checksum);
      end
`endif
   endtask

   task automatic test_backpressure();
      int base;
      base = we_count;
      pulse_start();
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("FAIL restart_done: got %b required 0", done);
      end
      step();
      expect_word(0, 8'h10, 8'h11, 8'h12, 8'h13);
      expect_word(1, 8'h14, 8'h15, 8'h16, 8'h17);
      send_word(8'h10, 8'h11, 8'h12, 8'h13);
      bus.in_data = 8'h14;
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL bp_write_ready: in_ready %b busy %b required 0 1", bus.in_ready, busy);
      end
      step();
      send_word(8'h14, 8'h15, 8'h16, 8'h17);
      bus.in_valid = 1'b0;
      wait_done();
      idle(2);
      checks++;
      if (we_count - base != 2 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL bp_writes: got %0d writes %0d pending required 2 0", we_count - base, exp_q.size());
      end
   endtask

   task automatic test_abort();
      int base;
      base = we_count;
      pulse_start();
      send_byte(8'h55);
      send_byte(8'h66);
      bus.in_valid = 1'b0;
      pulse_abort();
      @(negedge clk);
      checks++;
      if ({busy, done, bus.in_ready} !== 3'b000) begin
         errors++;
         $display("FAIL abort_idle: busy/done/in_ready got %b required 000", {busy, done, bus.in_ready});
      end
      step();
      idle(3);
      checks++;
      if (we_count != base) begin
         errors++;
         $display("FAIL abort_no_write: got %0d writes required 0", we_count - base);
      end
      pulse_start();
      expect_word(0, 8'hAA, 8'hBB, 8'hCC, 8'hDD);
      send_word(8'hAA, 8'hBB, 8'hCC, 8'hDD);
      bus.in_valid = 1'b0;
      idle(3);
      checks++;
      if (we_count - base != 1 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL abort_reload: got %0d writes %0d pending required 1 0", we_count - base, exp_q.size());
      end
      pulse_abort();
   endtask

   task automatic test_abort_write();
      int base;
      base = we_count;
      pulse_start();
      send_word(8'h01, 8'h02, 8'h03, 8'h04);
      bus.in_valid = 1'b0;
      pulse_abort();
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL abort_write_state: busy %b done %b required 0 0", busy, done);
      end
      step();
      idle(3);
      checks++;
      if (we_count != base) begin
         errors++;
         $display("FAIL abort_write_we: got %0d writes required 0", we_count - base);
      end
      start = 1'b1;
      abort = 1'b1;
      step();
      start = 1'b0;
      abort = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || bus.in_ready !== 1'b0) begin
         errors++;
         $display("FAIL abort_start: busy %b in_ready %b required 0 0", busy, bus.in_ready);
      end
      step();
   endtask

   task automatic test_start_ignored();
      pulse_start();
      expect_word(0, 8'h21, 8'h22, 8'h23, 8'h24);
      send_word(8'h21, 8'h22, 8'h23, 8'h24);
      bus.in_valid = 1'b0;
      idle(2);
      pulse_start();
      expect_word(1, 8'h25, 8'h26, 8'h27, 8'h28);
      send_word(8'h25, 8'h26, 8'h27, 8'h28);
      bus.in_valid = 1'b0;
      wait_done();
      idle(2);
      checks++;
      if (done !== 1'b1 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL start_fill_ignored: done %b pending %0d required 1 0", done, exp_q.size());
      end
      pulse_start();
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL done_restart: done %b busy %b required 0 1", done, busy);
      end
      step();
      expect_word(0, 8'h31, 8'h32, 8'h33, 8'h34);
      send_word(8'h31, 8'h32, 8'h33, 8'h34);
      bus.in_valid = 1'b0;
      idle(3);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL restart_write: got %0d pending required 0", exp_q.size());
      end
      pulse_abort();
   endtask

   task automatic test_reset_mid_fill();
      pulse_start();
      send_byte(8'hFF);
      send_byte(8'hFF);
      send_byte(8'hFF);
      #3;
      reset = 1'b1;
      #1;
      checks++;
      if ({busy, done, bus.in_ready, bus.we_b0, bus.we_b1, bus.we_b2, bus.we_b3} !== 7'b0 ||
          {bus.addr_b, bus.data_b0, bus.data_b1, bus.data_b2, bus.data_b3, checksum} !== '0) begin
         errors++;
         $display("FAIL reset_mid_fill: ctrl %b addr %h data %h%h%h%h cksum %h required all 0",
                  {busy, done, bus.in_ready, bus.we_b0, bus.we_b1, bus.we_b2, bus.we_b3}, bus.addr_b,
                  bus.data_b3, bus.data_b2, bus.data_b1, bus.data_b0, checksum);
      end
      bus.in_valid = 1'b0;
      step();
      reset = 1'b0;
      step();
      pulse_start();
      expect_word(0, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
      expect_word(1, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
      for (int i = 0; i < 8; i++) send_byte(8'hFF);
      bus.in_valid = 1'b0;
      wait_done();
      idle(2);
`ifdef IMAGE_WRITER_CHECKSUM_EN
      checks++;
      if (checksum !== 16'h07F8) begin
         errors++;
         $display("FAIL checksum_ff: got %h required 07f8", checksum);
      end
`else
      checks++;
      if (checksum !== 16'h0000) begin
         errors++;
         $display("FAIL checksum_ff: got %h required 0000", checksum);
      end
`endif
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL reset_reload: got %0d pending required 0", exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_abort();
      test_abort_write();
      test_start_ignored();
      test_reset_mid_fill();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
